// File: rtl/zone_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zone_pkt_pkg
//  Description : Shared constants, state encodings and helpers for the
//                zone detection packet receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package zone_pkt_pkg;

  localparam logic [7:0] ZONE_HDR = 8'hA5;
  localparam int         ZONE_N   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } byte_state_t;

  typedef enum logic [1:0] {
    WAIT_HDR = 2'd0,
    GET_D0   = 2'd1,
    GET_D1   = 2'd2,
    GET_CHK  = 2'd3
  } pkt_state_t;

  // Index of the lowest set bit; 4'hF when no zone is active.
  function automatic logic [3:0] lowest_set(input logic [ZONE_N-1:0] mask);
    logic [3:0] idx;
    idx = 4'hF;
    for (int i = ZONE_N - 1; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART byte receiver with 16x oversampling.
//                Ports: clk, reset (sync, active high), i_rx (async line),
//                o_byte_valid / o_frame_err (1-cycle pulses), o_data (byte
//                valid with o_byte_valid), o_tick (16x baud tick).
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_byte
  import zone_pkt_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic [7:0] o_data,
  output logic       o_tick
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  byte_state_t      r_state;
  logic [3:0]       r_tick_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_byte_valid;
  logic             r_frame_err;

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_tick_cnt   <= 4'd0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_data       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // Falling edge only: a line held low after a bad stop bit must
          // return high before another byte can begin.
          if (r_rx_prev && !r_rx_sync) begin
            r_state    <= START;
            r_tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd7) begin
              r_tick_cnt <= 4'd0;
              r_bit_cnt  <= 3'd0;
              r_state    <= r_rx_sync ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd15) begin
              r_tick_cnt <= 4'd0;
              r_shift    <= {r_rx_sync, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) begin
                r_state <= STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd15) begin
              r_tick_cnt <= 4'd0;
              r_state    <= IDLE;
              if (r_rx_sync) begin
                r_byte_valid <= 1'b1;
                r_data       <= r_shift;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
  assign o_data       = r_data;
  assign o_tick       = w_tick;

endmodule
`default_nettype wire

// File: rtl/zone_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module      : zone_packet_rx
//  Description : Receives the 4-byte zone packet (A5, D0, D1, CHK) over
//                UART, validates it and latches the 9-bit zone mask plus the
//                lowest active zone index.
//                Ports: clk, reset (sync, active high), i_rx (UART line),
//                o_zone_mask, o_zone_valid (pulse), o_target_idx,
//                o_pkt_err (pulse), o_err_count (saturating).
//  Revision    : 1.0  initial release
// ============================================================================
module zone_packet_rx
  import zone_pkt_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rx,
  output logic [ZONE_N-1:0] o_zone_mask,
  output logic              o_zone_valid,
  output logic [3:0]        o_target_idx,
  output logic              o_pkt_err,
  output logic [7:0]        o_err_count
);

  localparam int TO_LIMIT = TIMEOUT_BITS * 16;
  localparam int TO_W     = $clog2(TO_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic              w_byte_valid;
  logic              w_frame_err;
  logic [7:0]        w_data;
  logic              w_tick;
  logic              w_timeout;
  logic              w_err;
  logic              w_commit;
  logic [7:0]        w_chk;

  pkt_state_t        r_pkt_state;
  logic [7:0]        r_d0;
  logic              r_d1;
  logic [TO_W-1:0]   r_to_cnt;
  logic [ZONE_N-1:0] r_zone_mask;
  logic              r_zone_valid;
  logic [3:0]        r_target_idx;
  logic              r_pkt_err;
  logic [7:0]        r_err_count;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx_byte (
    .clk          (clk),
    .reset        (reset),
    .i_rx         (i_rx),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err),
    .o_data       (w_data),
    .o_tick       (w_tick)
  );

  assign w_chk     = ZONE_HDR ^ r_d0 ^ {7'd0, r_d1};
  assign w_timeout = (r_pkt_state != WAIT_HDR) && w_tick && (r_to_cnt == TO_LAST);

  // A received byte takes priority over a timeout in the same cycle.
  always_comb begin
    w_err    = 1'b0;
    w_commit = 1'b0;
    if (w_byte_valid) begin
      case (r_pkt_state)
        GET_D1:  w_err = |w_data[7:1];
        GET_CHK: begin
          if (w_data == w_chk) w_commit = 1'b1;
          else                 w_err    = 1'b1;
        end
        default: ;
      endcase
    end else if (w_frame_err && (r_pkt_state != WAIT_HDR)) begin
      w_err = 1'b1;
    end else if (w_timeout) begin
      w_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_state  <= WAIT_HDR;
      r_d0         <= 8'd0;
      r_d1         <= 1'b0;
      r_to_cnt     <= '0;
      r_zone_mask  <= '0;
      r_zone_valid <= 1'b0;
      r_target_idx <= 4'hF;
      r_pkt_err    <= 1'b0;
      r_err_count  <= 8'd0;
    end else begin
      r_zone_valid <= w_commit;
      r_pkt_err    <= w_err;

      if (w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end

      if (w_commit) begin
        r_zone_mask  <= {r_d1, r_d0};
        r_target_idx <= lowest_set({r_d1, r_d0});
      end

      if (w_byte_valid || w_err || (r_pkt_state == WAIT_HDR)) begin
        r_to_cnt <= '0;
      end else if (w_tick) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (w_err) begin
        r_pkt_state <= WAIT_HDR;
      end else if (w_byte_valid) begin
        case (r_pkt_state)
          WAIT_HDR: if (w_data == ZONE_HDR) r_pkt_state <= GET_D0;
          GET_D0: begin
            r_d0        <= w_data;
            r_pkt_state <= GET_D1;
          end
          GET_D1: begin
            r_d1        <= w_data[0];
            r_pkt_state <= GET_CHK;
          end
          GET_CHK: r_pkt_state <= WAIT_HDR;
          default: r_pkt_state <= WAIT_HDR;
        endcase
      end
    end
  end

  assign o_zone_mask  = r_zone_mask;
  assign o_zone_valid = r_zone_valid;
  assign o_target_idx = r_target_idx;
  assign o_pkt_err    = r_pkt_err;
  assign o_err_count  = r_err_count;

endmodule
`default_nettype wire
